wash_phase_timer: RTL
=====================

Name: wash_phase_timer

Overview:
- Upstream sensor/timing stage for the washing-machine control FSM.
- Conditions the raw 8-bit water-level sensor into debounced Filled/Drained levels.
- Times the wash and spin phases from the controller's actuator outputs, producing single-cycle Cycle_Timeout/Spin_Timeout pulses.
- Runs a fill watchdog that latches Fault; all outputs registered.

Parameters:
PRESCALE, 100, clocks per timebase tick (>=2)
CYCLE_TICKS, 1000, wash duration in ticks (>=1)
SPIN_TICKS, 500, spin duration in ticks (>=1)
FILL_LIMIT, 300, max fill ticks before Fault (>=1)
FULL_LEVEL, 200, Level threshold for Filled
EMPTY_LEVEL, 10, Level threshold for Drained (< FULL_LEVEL)
DEBOUNCE, 4, consecutive clocks needed to change a level flag (>=1)
TW, 16, tick counter width

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Level  input  8  raw water-level sensor, unsigned
Motor_on  input  1  from controller, wash motor
Fill_valve_on  input  1  from controller
Drained_valve_on  input  1  from controller
Door_Lock  input  1  from controller; 0 = machine idle/unlocked
Filled  output  1  debounced Level >= FULL_LEVEL
Drained  output  1  debounced Level <= EMPTY_LEVEL
Cycle_Timeout  output  1  one-clock pulse, wash time elapsed
Spin_Timeout  output  1  one-clock pulse, spin time elapsed
Fault  output  1  latched fill-watchdog fault
Phase  output  3  current phase code, debug

Behaviour:
- Reset: Reset asynchronous, active-low; clock Clock.
  - Reset=0 forces Filled=0, Drained=0, Cycle_Timeout=0, Spin_Timeout=0, Fault=0, Phase=IDLE.
  - All counters, including the prescaler and debounce counters, clear to 0.
  - Reset mid-operation aborts any phase, with no pulse emitted.
- Prescaler:
  - Counts 0..PRESCALE-1 while Door_Lock=1; held at 0 while Door_Lock=0.
  - tick is high for one clock when the count equals PRESCALE-1, then the count wraps to 0.
- Debounce, per flag:
  - Compare is registered: full_raw = Level>=FULL_LEVEL, empty_raw = Level<=EMPTY_LEVEL.
  - A flag changes only after its raw value differs from the flag for DEBOUNCE consecutive clocks.
  - Any clock where raw equals the flag clears that debounce counter.
  - Latency from a stable Level change to the flag change is DEBOUNCE+1 clocks.
  - Runs independently of Door_Lock.
- Phase FSM; codes IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4; one tick counter tcnt[TW-1:0] is shared.
  - IDLE: tcnt=0. Next state by priority:
    - Fill_valve_on -> FILL
    - else Motor_on -> WASH
    - else Drained_valve_on&!Drained -> DRAIN
    - else Drained_valve_on&Drained -> SPIN
  - FILL: tcnt++ on tick.
    - If tcnt reaches FILL_LIMIT-1 on a tick with Filled=0: set Fault=1, stay in FILL.
    - Fill_valve_on=0 -> IDLE, tcnt=0.
  - WASH: tcnt++ on tick.
    - On a tick with tcnt==CYCLE_TICKS-1: Cycle_Timeout=1 for the next clock only, -> IDLE, tcnt=0.
    - Motor_on=0 before expiry: abort -> IDLE, no pulse.
  - DRAIN: no timing. Drained=1 with Drained_valve_on=1 -> SPIN, tcnt=0. Drained_valve_on=0 -> IDLE.
  - SPIN: tcnt++ on tick, only while Drained=1; tcnt holds (pauses) while Drained=0.
    - On a tick with tcnt==SPIN_TICKS-1: Spin_Timeout=1 for one clock, -> IDLE.
    - Drained_valve_on=0 -> IDLE, no pulse.
  - Door_Lock=0 in any state: -> IDLE next clock, tcnt=0, pulses suppressed.
- Timing and pulse rules:
  - Pulses are registered: high exactly one clock after the expiring tick edge.
  - The controller advances on that same clock. The FSM sits in IDLE during the pulse clock, so a back-to-back phase cannot be re-armed the same cycle.
  - Wash elapsed time = CYCLE_TICKS*PRESCALE clocks from WASH entry, ±1 prescaler period, because the prescaler is free-running under Door_Lock.
  - tcnt saturates at 2^TW-1, never wraps.
- Fault:
  - Sticky; cleared only by Reset=0 or a clock with Door_Lock=0.
  - A simultaneous Filled=1 on the expiry tick suppresses Fault (Filled wins).
- Phase output mirrors the state register.

Test Plan:
- Level ramps 0->220 and holds; FULL_LEVEL=200, DEBOUNCE=4 -> Filled rises exactly 5 clocks after Level first >=200. A 3-clock glitch to 190 leaves Filled=1.
- PRESCALE=4, CYCLE_TICKS=3; Door_Lock=1, Motor_on held 1 -> exactly one Cycle_Timeout pulse of width 1 at 12±4 clocks after WASH entry; Phase returns to 0.
- Motor_on drops after 1 tick in WASH -> no Cycle_Timeout; Phase=0; tcnt restarts at 0 on re-entry.
- SPIN_TICKS=5 with Drained forced low for 2 ticks mid-spin -> Spin_Timeout after 7 ticks total, one clock wide.
- FILL_LIMIT=3, Fill_valve_on=1, Level=0 -> Fault=1 after 3 ticks and stays 1. Door_Lock=0 for one clock -> Fault=0, Phase=0.
- Reset asserted during SPIN with tcnt=4 -> all outputs 0 immediately (asynchronous), no Spin_Timeout after release.

Source files
------------

// File: rtl/wash_phase_timer.sv
// wash_phase_timer
//   Sensor and timing stage that sits in front of the washing-machine
//   control FSM. It debounces the raw water-level sensor into Filled and
//   Drained, times the wash and spin phases from the controller's actuator
//   outputs, and runs a fill watchdog that latches Fault.
//
// Ports
//   Clock            system clock
//   Reset            asynchronous, active-low reset
//   Level[7:0]       raw water-level sensor, unsigned
//   Motor_on         wash motor request from the controller
//   Fill_valve_on    fill valve request from the controller
//   Drained_valve_on drain valve request from the controller
//   Door_Lock        0 means the machine is idle/unlocked
//   Filled           debounced Level >= FULL_LEVEL
//   Drained          debounced Level <= EMPTY_LEVEL
//   Cycle_Timeout    one-clock pulse when the wash time has elapsed
//   Spin_Timeout     one-clock pulse when the spin time has elapsed
//   Fault            latched fill-watchdog fault
//   Phase[2:0]       current phase code (debug)
//
// All outputs come straight from flops.

module wash_phase_timer #(
  parameter int PRESCALE    = 100,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int FILL_LIMIT  = 300,
  parameter int FULL_LEVEL  = 200,
  parameter int EMPTY_LEVEL = 10,
  parameter int DEBOUNCE    = 4,
  parameter int TW          = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Level,
  input  logic       Motor_on,
  input  logic       Fill_valve_on,
  input  logic       Drained_valve_on,
  input  logic       Door_Lock,
  output logic       Filled,
  output logic       Drained,
  output logic       Cycle_Timeout,
  output logic       Spin_Timeout,
  output logic       Fault,
  output logic [2:0] Phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    SPIN  = 3'd4
  } phase_e;

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [7:0]    FULL_TH    = 8'(FULL_LEVEL);
  localparam logic [7:0]    EMPTY_TH   = 8'(EMPTY_LEVEL);
  localparam logic [TW-1:0] FILL_LAST  = TW'(FILL_LIMIT - 1);
  localparam logic [TW-1:0] CYCLE_LAST = TW'(CYCLE_TICKS - 1);
  localparam logic [TW-1:0] SPIN_LAST  = TW'(SPIN_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic          full_raw_q, full_raw_d;
  logic          empty_raw_q, empty_raw_d;
  logic [DW-1:0] full_cnt_q, full_cnt_d;
  logic [DW-1:0] empty_cnt_q, empty_cnt_d;
  logic          filled_q, filled_d;
  logic          drained_q, drained_d;

  phase_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic          fault_q, fault_d;
  logic          cycle_to_q, cycle_to_d;
  logic          spin_to_q, spin_to_d;

  // The prescaler only runs while the door is locked, so every phase
  // starts from a prescaler that is already free-running.
  always_comb begin
    tick    = Door_Lock && (presc_q == PRESC_LAST);
    presc_d = presc_q + 1'b1;
    if (!Door_Lock || tick) begin
      presc_d = '0;
    end
  end

  // Level thresholds are registered first; each flag then needs its
  // registered raw value to disagree for DEBOUNCE clocks in a row before
  // it follows, and any agreeing clock restarts the count.
  always_comb begin
    full_raw_d  = (Level >= FULL_TH);
    empty_raw_d = (Level <= EMPTY_TH);

    filled_d   = filled_q;
    full_cnt_d = '0;
    if (full_raw_q != filled_q) begin
      if (full_cnt_q == DB_LAST) begin
        filled_d = full_raw_q;
      end else begin
        full_cnt_d = full_cnt_q + 1'b1;
      end
    end

    drained_d   = drained_q;
    empty_cnt_d = '0;
    if (empty_raw_q != drained_q) begin
      if (empty_cnt_q == DB_LAST) begin
        drained_d = empty_raw_q;
      end else begin
        empty_cnt_d = empty_cnt_q + 1'b1;
      end
    end
  end

  // The shared tick counter saturates instead of wrapping.
  assign tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;

  // Phase FSM. Expiry goes straight back to IDLE, so the pulse clock is
  // always spent in IDLE and the controller cannot re-arm on that clock.
  // Controller requests dropping always win over an expiring tick.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    fault_d    = fault_q;
    cycle_to_d = 1'b0;
    spin_to_d  = 1'b0;

    if (!Door_Lock) begin
      state_d = IDLE;
      tcnt_d  = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (Fill_valve_on) begin
            state_d = FILL;
          end else if (Motor_on) begin
            state_d = WASH;
          end else if (Drained_valve_on) begin
            state_d = drained_q ? SPIN : DRAIN;
          end
        end
        FILL: begin
          if (!Fill_valve_on) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (tick) begin
            tcnt_d = tcnt_inc;
            // A tank that reports full on the expiry tick is not a fault.
            if ((tcnt_q == FILL_LAST) && !filled_q) begin
              fault_d = 1'b1;
            end
          end
        end
        WASH: begin
          if (!Motor_on) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (tick) begin
            if (tcnt_q == CYCLE_LAST) begin
              cycle_to_d = 1'b1;
              state_d    = IDLE;
              tcnt_d     = '0;
            end else begin
              tcnt_d = tcnt_inc;
            end
          end
        end
        DRAIN: begin
          if (!Drained_valve_on) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (drained_q) begin
            state_d = SPIN;
            tcnt_d  = '0;
          end
        end
        SPIN: begin
          if (!Drained_valve_on) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (tick && drained_q) begin
            // Spin time only accrues while the tank reads drained.
            if (tcnt_q == SPIN_LAST) begin
              spin_to_d = 1'b1;
              state_d   = IDLE;
              tcnt_d    = '0;
            end else begin
              tcnt_d = tcnt_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q     <= '0;
      full_raw_q  <= 1'b0;
      empty_raw_q <= 1'b0;
      full_cnt_q  <= '0;
      empty_cnt_q <= '0;
      filled_q    <= 1'b0;
      drained_q   <= 1'b0;
      state_q     <= IDLE;
      tcnt_q      <= '0;
      fault_q     <= 1'b0;
      cycle_to_q  <= 1'b0;
      spin_to_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      full_raw_q  <= full_raw_d;
      empty_raw_q <= empty_raw_d;
      full_cnt_q  <= full_cnt_d;
      empty_cnt_q <= empty_cnt_d;
      filled_q    <= filled_d;
      drained_q   <= drained_d;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      fault_q     <= fault_d;
      cycle_to_q  <= cycle_to_d;
      spin_to_q   <= spin_to_d;
    end
  end

  assign Filled        = filled_q;
  assign Drained       = drained_q;
  assign Cycle_Timeout = cycle_to_q;
  assign Spin_Timeout  = spin_to_q;
  assign Fault         = fault_q;
  assign Phase         = state_q;

endmodule
